adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
- Sequences the single-channel 14-bit SPI ADC reader across up to 8 analog-mux inputs.
- Per scan: drives the mux select, waits for the analog input to settle, issues the ADC `go`, collects 2^AVG_LOG2 samples per channel, averages them and stores one result per channel in a readback register file.
- Sits between the host/register interface and the ADC SPI reader; it is the only block that drives the reader's `go`.
- Supports one-shot scans and periodic continuous scans.

Parameters:
- CHANNELS, 8: number of mux channels (2..8).
- CH_BITS, 3: width of the channel index.
- ADC_BITS, 14: ADC sample width.
- SETTLE_CYCLES, 16: clkin cycles to wait after a mux change before `go` (≥1).
- AVG_LOG2, 2: log2 of samples averaged per channel (0..4).
- PERIOD, 50000: clkin cycles between scan starts in continuous mode.

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low aborts and idles.
- continuous  in  1  1 = rescan every PERIOD cycles; 0 = one-shot only.
- start  in  1  one-cycle pulse: begin a scan (ignored while busy).
- chan_mask  in  CHANNELS  channels included in a scan; sampled at scan start.
- mux_sel  out  CH_BITS  analog mux select.
- adc_go  out  1  to ADC reader `go`.
- adc_busy  in  1  ADC reader `state` (1 = transferring).
- adc_data  in  ADC_BITS  ADC reader `data_o`.
- rd_chan  in  CH_BITS  readback channel index.
- rd_data  out  ADC_BITS  averaged result of rd_chan (combinational read).
- rd_valid  out  1  rd_chan holds a result written since reset or since the last enable rise.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at the end of a scan.
- overrun  out  1  sticky: period expired while a scan was still running.

Behaviour:
- Reset values (rst_n low, asynchronous): mux_sel=0, adc_go=0, busy=0, scan_done=0, overrun=0, all results=0, all valid bits=0, period counter=0, FSM=IDLE.
- States: IDLE, SELECT, SETTLE, START, CONV, STORE, DRAIN.
- IDLE: a scan starts on `start`, or on period expiry when continuous=1.
  - Latch chan_mask; set busy=1.
  - Channel pointer = lowest set bit.
  - If the latched mask is 0: scan_done pulses the next cycle and the FSM returns to IDLE with no conversions.
- SELECT: mux_sel <= pointer; clear accumulator and sample count; load the settle counter with SETTLE_CYCLES → SETTLE.
- SETTLE: decrement the counter; at 0 → START.
- START: adc_go=1, held until adc_busy=1 is sampled, then deassert → CONV.
- CONV: wait for adc_busy=0; capture adc_data into the accumulator (width ADC_BITS+AVG_LOG2, no overflow possible) → STORE.
- STORE:
  - If sample count < 2^AVG_LOG2−1: increment count → START. No re-settle, because the mux is unchanged.
  - Otherwise: write result[pointer] = accumulator >> AVG_LOG2 (truncate) and set valid[pointer].
  - Then advance to the next higher set mask bit → SELECT.
  - If no set bit remains: busy=0, scan_done=1 for one cycle → IDLE.
- Period counter:
  - Free-runs 0..PERIOD−1 while enable=1 and continuous=1; expires on wrap; held at 0 otherwise.
  - Expiry while busy: set overrun and drop the trigger; the current scan continues.
- enable low:
  - In SELECT/SETTLE: → IDLE immediately.
  - In START/CONV/STORE: → DRAIN, which waits for adc_busy=0 (the reader cannot be aborted); no result is written; → IDLE.
  - adc_go=0 on the first cycle enable is low.
  - busy stays 1 through DRAIN; no scan_done on abort.
- Rising edge of enable: clear all valid bits and overrun.
- start while busy: ignored; no overrun.
- start coincident with period expiry: a single scan.
- rd_chan ≥ CHANNELS: rd_data=0, rd_valid=0.
- Timing: adc_go rises SETTLE_CYCLES+2 cycles after the start pulse. Given the reader's 1-cycle accept and 2·ADC_BITS-cycle transfer, one sample takes ≈ 2·ADC_BITS+3 cycles.

Test Plan:
- Reset mid-CONV (rst_n low for 1 cycle) → all outputs at reset values immediately, asynchronously; adc_go=0.
- AVG_LOG2=0, mask=8'b0000_0101, start pulse, ADC model returns 0x1234 on ch0 and 0x0ABC on ch2 → mux_sel sequence 0 then 2; exactly 2 go handshakes; rd_data(0)=0x1234, rd_data(2)=0x0ABC; valid only for 0 and 2; one scan_done.
- AVG_LOG2=2, mask=8'b0000_0010, samples 100, 101, 102, 104 → result[1]=101 (407>>2); 4 go pulses; single SETTLE period.
- mask=0 with start → scan_done one cycle later; adc_go never asserted.
- continuous=1, PERIOD=100 (scan longer than 100 cycles) → overrun sets on the first expiry during the scan; scans restart only from IDLE.
- enable dropped during CONV → adc_go stays 0; busy holds until adc_busy falls; no result or valid bit written; no scan_done.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for a single SPI ADC behind an analog mux: settles, converts,
// averages 2^AVG_LOG2 samples per selected channel and keeps one result per channel.
module adc_scan_sequencer #(
    parameter int CHANNELS      = 8,
    parameter int CH_BITS       = 3,
    parameter int ADC_BITS      = 14,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 2,
    parameter int PERIOD        = 50000
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                continuous,
    input  logic                start,
    input  logic [CHANNELS-1:0] chan_mask,
    output logic [CH_BITS-1:0]  mux_sel,
    output logic                adc_go,
    input  logic                adc_busy,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic [CH_BITS-1:0]  rd_chan,
    output logic [ADC_BITS-1:0] rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                scan_done,
    output logic                overrun,
    output logic [2:0]          dbg_state
);
    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int SW    = $clog2(SETTLE_CYCLES + 1);
    localparam int PW    = $clog2(PERIOD);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_START, S_CONV, S_STORE, S_DRAIN
    } state_t;

    state_t              state, next_state;
    logic [CHANNELS-1:0] mask_q;
    logic [CH_BITS-1:0]  ptr, first_ch, next_ch;
    logic                first_hit, next_hit;
    logic [SW-1:0]       settle_cnt;
    logic [ACC_W-1:0]    acc;
    logic [4:0]          scnt;
    logic [PW-1:0]       pcnt;
    logic [ADC_BITS-1:0] result [CHANNELS];
    logic [CHANNELS-1:0] valid;
    logic                en_q, period_expire, trigger, last_sample;

    // Handshake: adc_go is held while in START until adc_busy is seen high
    // (reader accepted); adc_busy falling marks adc_data as the finished sample.
    assign adc_go        = (state == S_START) && enable;
    assign period_expire = enable && continuous && (pcnt == PW'(PERIOD - 1));
    assign trigger       = enable && (start || period_expire);
    assign last_sample   = (scnt == 5'(NSAMP - 1));
    assign dbg_state     = state;

    always_comb begin
        first_ch  = '0;
        first_hit = 1'b0;
        next_ch   = '0;
        next_hit  = 1'b0;
        // Descending scan so the lowest qualifying index wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_ch  = CH_BITS'(i);
                first_hit = 1'b1;
            end
            if (mask_q[i] && (i > int'(ptr))) begin
                next_ch  = CH_BITS'(i);
                next_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (trigger && first_hit) next_state = S_SELECT;
            S_SELECT: next_state = enable ? S_SETTLE : S_IDLE;
            S_SETTLE: if (!enable) next_state = S_IDLE;
                      else if (settle_cnt == SW'(1)) next_state = S_START;
            S_START:  if (!enable) next_state = S_DRAIN;
                      else if (adc_busy) next_state = S_CONV;
            S_CONV:   if (!enable) next_state = S_DRAIN;
                      else if (!adc_busy) next_state = S_STORE;
            S_STORE:  if (!enable) next_state = S_DRAIN;
                      else if (!last_sample) next_state = S_START;
                      else if (next_hit) next_state = S_SELECT;
                      else next_state = S_IDLE;
            S_DRAIN:  if (!adc_busy) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel    <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            overrun    <= 1'b0;
            mask_q     <= '0;
            ptr        <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            scnt       <= '0;
            pcnt       <= '0;
            result     <= '{default: '0};
            valid      <= '0;
            en_q       <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            en_q      <= enable;
            busy      <= (next_state != S_IDLE);

            if (enable && continuous) pcnt <= period_expire ? '0 : pcnt + PW'(1);
            else                      pcnt <= '0;

            if (enable && !en_q) begin
                valid   <= '0;
                overrun <= 1'b0;
            end else if (period_expire && busy) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: if (trigger) begin
                    mask_q <= chan_mask;
                    ptr    <= first_ch;
                    if (!first_hit) scan_done <= 1'b1;
                end
                S_SELECT: begin
                    mux_sel    <= ptr;
                    acc        <= '0;
                    scnt       <= '0;
                    settle_cnt <= SW'(SETTLE_CYCLES);
                end
                S_SETTLE: settle_cnt <= settle_cnt - SW'(1);
                S_CONV:   if (enable && !adc_busy) acc <= acc + ACC_W'(adc_data);
                S_STORE:  if (enable) begin
                    if (!last_sample) begin
                        scnt <= scnt + 5'd1;
                    end else begin
                        result[ptr] <= acc[AVG_LOG2 +: ADC_BITS];
                        valid[ptr]  <= 1'b1;
                        ptr         <= next_ch;
                        if (!next_hit) scan_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (int'(rd_chan) < CHANNELS) begin
            rd_data  = result[rd_chan];
            rd_valid = valid[rd_chan];
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer with a behavioural ADC reader and a
// per-channel averaging reference model.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;
    localparam int CHANNELS = 6;
    localparam int CH_BITS  = 3;
    localparam int ADC_BITS = 14;
    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 2;
    localparam int PERIOD   = 100;
    localparam int NSAMP    = 1 << AVG_LOG2;
    localparam int XFER     = 2 * ADC_BITS;

    logic                clkin = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                continuous = 1'b0;
    logic                start = 1'b0;
    logic [CHANNELS-1:0] chan_mask = '0;
    logic [CH_BITS-1:0]  rd_chan = '0;
    logic [CH_BITS-1:0]  mux_sel;
    logic                adc_go, adc_busy, busy, scan_done, overrun, rd_valid;
    logic [ADC_BITS-1:0] adc_data, rd_data;
    logic [2:0]          dbg_state;

    adc_scan_sequencer #(
        .CHANNELS(CHANNELS), .CH_BITS(CH_BITS), .ADC_BITS(ADC_BITS),
        .SETTLE_CYCLES(SETTLE), .AVG_LOG2(AVG_LOG2), .PERIOD(PERIOD)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .enable(enable), .continuous(continuous),
        .start(start), .chan_mask(chan_mask), .mux_sel(mux_sel), .adc_go(adc_go),
        .adc_busy(adc_busy), .adc_data(adc_data), .rd_chan(rd_chan),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .scan_done(scan_done), .overrun(overrun), .dbg_state(dbg_state)
    );

    // clock / reset
    always #10 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    int n_done = 0;
    int done_cyc = 0;
    always @(negedge clkin) if (scan_done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
    end

    // ADC reader model: accepts go, stays busy for XFER cycles, then presents data
    logic [ADC_BITS-1:0] forced_q[$];
    logic [ADC_BITS-1:0] samp_q[$];
    logic [CH_BITS-1:0]  mux_q[$];
    int                  go_cyc_q[$];

    initial begin
        logic [ADC_BITS-1:0] v;
        adc_busy = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clkin);
            if (adc_go && !adc_busy) begin
                if (forced_q.size() > 0) v = forced_q.pop_front();
                else v = ADC_BITS'($urandom_range(0, (1 << ADC_BITS) - 1));
                samp_q.push_back(v);
                mux_q.push_back(mux_sel);
                go_cyc_q.push_back(cyc);
                adc_busy = 1'b1;
                repeat (XFER) @(negedge clkin);
                adc_data = v;
                adc_busy = 1'b0;
            end
        end
    end

    // scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [ADC_BITS-1:0] exp_res [CHANNELS];
    logic                exp_val [CHANNELS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            exp_res[ch] = '0;
            exp_val[ch] = 1'b0;
        end
    endtask

    task automatic model_clear_valid();
        for (int ch = 0; ch < CHANNELS; ch++) exp_val[ch] = 1'b0;
    endtask

    // Every selected channel, lowest first, gets NSAMP consecutive conversions
    // whose truncated mean becomes its result.
    task automatic model_scan(input logic [CHANNELS-1:0] mask);
        logic [CH_BITS-1:0] exp_q[$];
        int sum, errs;
        errs = 0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (mask[ch]) begin
                sum = 0;
                for (int s = 0; s < NSAMP; s++) begin
                    exp_q.push_back(CH_BITS'(ch));
                    if (samp_q.size() > 0) sum += int'(samp_q.pop_front());
                end
                exp_res[ch] = ADC_BITS'(sum / NSAMP);
                exp_val[ch] = 1'b1;
            end
        end
        check("go_count", mux_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mux_q.size(); i++)
            if (mux_q[i] !== exp_q[i]) errs++;
        check("mux_seq", errs, 0);
    endtask

    task automatic check_readback(input string tag);
        for (int ch = 0; ch < (1 << CH_BITS); ch++) begin
            rd_chan = CH_BITS'(ch);
            #1;
            if (ch < CHANNELS) begin
                check({tag, "_data"}, rd_data, exp_res[ch]);
                check({tag, "_valid"}, rd_valid, exp_val[ch]);
            end else begin
                check({tag, "_oor_data"}, rd_data, 0);
                check({tag, "_oor_valid"}, rd_valid, 0);
            end
        end
    endtask

    task automatic clear_logs();
        samp_q.delete();
        mux_q.delete();
        go_cyc_q.delete();
    endtask

    task automatic toggle_enable();
        @(negedge clkin); enable = 1'b0;
        @(negedge clkin); enable = 1'b1;
        @(negedge clkin); #1;
        model_clear_valid();
        check("en_rise_overrun", overrun, 0);
    endtask

    // driver: one-shot scan with optional extra start while busy
    task automatic run_scan(input logic [CHANNELS-1:0] mask, input bit poke);
        int t0, d0;
        bit timeout;
        clear_logs();
        @(negedge clkin);
        chan_mask = mask;
        start = 1'b1;
        t0 = cyc;
        d0 = n_done;
        @(negedge clkin);
        start = 1'b0;
        if (poke && mask != 0) begin
            repeat (30) @(negedge clkin);
            start = 1'b1;
            @(negedge clkin);
            start = 1'b0;
        end
        timeout = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            #1;
            if (n_done != d0) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clkin);
        end
        check("scan_timeout", timeout, 0);
        check("busy_after_done", busy, 0);
        if (mask == 0) check("empty_done_lat", done_cyc - t0, 1);
        else if (go_cyc_q.size() > 0) check("go_latency", go_cyc_q[0] - t0, SETTLE + 2);
        model_scan(mask);
        repeat (3) @(negedge clkin);
        #1;
        check("done_once", n_done - d0, 1);
        check("no_overrun", overrun, 0);
        check_readback("scan");
    endtask

    task automatic wait_adc(input logic level, input string tag);
        bit timeout;
        timeout = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clkin); #1;
            if (adc_busy == level) begin
                timeout = 1'b0;
                break;
            end
        end
        check(tag, timeout, 0);
    endtask

    initial begin
        int d0;
        bit dropped, timeout;
        model_reset();

        // reset state
        repeat (3) @(negedge clkin);
        #1;
        check("rst_mux_sel", mux_sel, 0);
        check("rst_adc_go", adc_go, 0);
        check("rst_busy", busy, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_overrun", overrun, 0);
        check_readback("rst");
        @(negedge clkin);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clkin);

        // two channels with fixed codes
        for (int i = 0; i < NSAMP; i++) forced_q.push_back(14'h1234);
        for (int i = 0; i < NSAMP; i++) forced_q.push_back(14'h0ABC);
        run_scan(6'b000101, 1'b0);

        // averaging with truncation: 407 >> 2 = 101
        forced_q.push_back(14'd100);
        forced_q.push_back(14'd101);
        forced_q.push_back(14'd102);
        forced_q.push_back(14'd104);
        run_scan(6'b000010, 1'b0);
        rd_chan = 3'd1; #1;
        check("avg_101", rd_data, 101);

        // empty mask
        run_scan('0, 1'b0);

        // random masks, some with an extra start while busy
        run_scan('1, 1'b1);
        for (int n = 0; n < 5; n++)
            run_scan(CHANNELS'($urandom_range(1, (1 << CHANNELS) - 1)), n[0]);

        // abort during a conversion
        toggle_enable();
        check_readback("en_rise");
        clear_logs();
        @(negedge clkin);
        chan_mask = 6'b000001;
        start = 1'b1;
        d0 = n_done;
        @(negedge clkin);
        start = 1'b0;
        wait_adc(1'b1, "abort_wait_conv");
        repeat (5) @(negedge clkin);
        enable = 1'b0;
        #1;
        check("abort_go_low", adc_go, 0);
        check("abort_busy_held", busy, 1);
        dropped = 1'b0;
        timeout = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clkin); #1;
            if (!adc_busy) begin
                timeout = 1'b0;
                break;
            end
            if (!busy || adc_go) dropped = 1'b1;
        end
        check("abort_drain_timeout", timeout, 0);
        check("abort_busy_through_drain", dropped, 0);
        @(negedge clkin); #1;
        check("abort_busy_released", busy, 0);
        repeat (5) @(negedge clkin);
        #1;
        check("abort_no_done", n_done - d0, 0);
        check("abort_go_count", mux_q.size(), 1);
        check_readback("abort");
        @(negedge clkin);
        enable = 1'b1;
        repeat (2) @(negedge clkin);

        // asynchronous reset mid-conversion
        @(negedge clkin);
        chan_mask = 6'b001000;
        start = 1'b1;
        @(negedge clkin);
        start = 1'b0;
        wait_adc(1'b1, "rst_wait_conv");
        repeat (3) @(negedge clkin);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_adc_go", adc_go, 0);
        check("arst_busy", busy, 0);
        check("arst_mux_sel", mux_sel, 0);
        check("arst_overrun", overrun, 0);
        check_readback("arst");
        @(negedge clkin);
        rst_n = 1'b1;
        wait_adc(1'b0, "rst_adc_idle");
        repeat (3) @(negedge clkin);
        #1;
        check("arst_stays_idle", busy, 0);

        // continuous mode with a scan longer than the period
        clear_logs();
        @(negedge clkin);
        chan_mask = 6'b000011;
        d0 = n_done;
        continuous = 1'b1;
        timeout = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clkin); #1;
            if (n_done != d0) begin
                timeout = 1'b0;
                break;
            end
        end
        continuous = 1'b0;
        check("cont_timeout", timeout, 0);
        check("cont_overrun", overrun, 1);
        model_scan(6'b000011);
        repeat (400) @(negedge clkin);
        #1;
        check("cont_single_scan", n_done - d0, 1);
        check("cont_overrun_sticky", overrun, 1);
        check_readback("cont");
        toggle_enable();
        check_readback("cont_en_rise");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
